// File: rtl/piece_drop_ctrl.sv
// piece_drop_ctrl: owns the active falling piece. It spawns from the shape
// generator, applies gravity on frame ticks, handles lateral moves, soft and
// hard drop and hold, and pulses touchdown back to the generator on lock.
//
// state      | meaning
// SPAWN_WAIT | one idle cycle so the generator can advance shape_num
// SPAWN      | latch shape_num, place piece at spawn, clear gravity count
// SPAWN_CHK  | spawn blocked -> OVER, otherwise piece becomes valid
// FALL       | normal play: one key action or one gravity step per cycle
// HARD       | hard drop: one row per cycle until blocked below
// LOCK       | touchdown pulse, piece retired
// OVER       | terminal until reset
module piece_drop_ctrl #(
  parameter int         GRAVITY_TICKS = 30,
  parameter int         SOFT_TICKS    = 3,
  parameter logic [3:0] SPAWN_X       = 4'd4,
  parameter logic [4:0] SPAWN_Y       = 5'd0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [15:0] keycode,
  input  logic [2:0]  shape_num,
  input  logic        collide_here,
  input  logic        collide_down,
  input  logic        collide_left,
  input  logic        collide_right,
  output logic [3:0]  piece_x,
  output logic [4:0]  piece_y,
  output logic [2:0]  piece_shape,
  output logic        piece_valid,
  output logic        touchdown,
  output logic        game_over
);

  localparam int MAX_TICKS = (GRAVITY_TICKS > SOFT_TICKS) ? GRAVITY_TICKS : SOFT_TICKS;
  localparam int CW = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] GRAV_TH = CW'(GRAVITY_TICKS);
  localparam logic [CW-1:0] SOFT_TH = CW'(SOFT_TICKS);

  localparam logic [15:0] KEY_NONE  = 16'h0000;
  localparam logic [15:0] KEY_LEFT  = 16'h0004;
  localparam logic [15:0] KEY_RIGHT = 16'h0007;
  localparam logic [15:0] KEY_SOFT  = 16'h0016;
  localparam logic [15:0] KEY_HARD  = 16'h002C;
  localparam logic [15:0] KEY_HOLD  = 16'h0013;

  typedef enum logic [2:0] {
    SPAWN_WAIT,
    SPAWN,
    SPAWN_CHK,
    FALL,
    HARD,
    LOCK,
    OVER
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      x_nxt;
  logic [4:0]      y_nxt;
  logic [2:0]      shape_nxt;
  logic            valid_nxt, over_nxt;
  logic [CW-1:0]   grav_cnt, cnt_nxt;
  logic            hold_used, hold_nxt;
  logic            key_armed, armed_nxt;

  logic            key_left, key_right, key_soft, key_hard, key_hold, key_edge;
  logic [CW-1:0]   threshold;
  logic            grav_pending;

  assign key_left  = (keycode == KEY_LEFT);
  assign key_right = (keycode == KEY_RIGHT);
  assign key_soft  = (keycode == KEY_SOFT);
  assign key_hard  = (keycode == KEY_HARD);
  assign key_hold  = (keycode == KEY_HOLD);
  // Only the edge-action keys consume key_armed; soft drop and unknown codes do not.
  assign key_edge  = key_left | key_right | key_hard | key_hold;

  assign threshold    = key_soft ? SOFT_TH : GRAV_TH;
  assign grav_pending = (grav_cnt >= threshold);

  // State and datapath registers, all reset to spawn-ready values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= SPAWN_WAIT;
      piece_x     <= SPAWN_X;
      piece_y     <= SPAWN_Y;
      piece_shape <= 3'd0;
      piece_valid <= 1'b0;
      game_over   <= 1'b0;
      grav_cnt    <= '0;
      hold_used   <= 1'b0;
      key_armed   <= 1'b1;
    end else begin
      state       <= state_nxt;
      piece_x     <= x_nxt;
      piece_y     <= y_nxt;
      piece_shape <= shape_nxt;
      piece_valid <= valid_nxt;
      game_over   <= over_nxt;
      grav_cnt    <= cnt_nxt;
      hold_used   <= hold_nxt;
      key_armed   <= armed_nxt;
    end
  end

  // Next-state, next-datapath and the touchdown strobe.
  always_comb begin
    state_nxt = state;
    x_nxt     = piece_x;
    y_nxt     = piece_y;
    shape_nxt = piece_shape;
    valid_nxt = piece_valid;
    over_nxt  = game_over;
    cnt_nxt   = grav_cnt;
    hold_nxt  = hold_used;
    armed_nxt = key_armed;
    touchdown = 1'b0;

    if (keycode == KEY_NONE) armed_nxt = 1'b1;

    case (state)
      SPAWN_WAIT: state_nxt = SPAWN;

      SPAWN: begin
        shape_nxt = shape_num;
        x_nxt     = SPAWN_X;
        y_nxt     = SPAWN_Y;
        cnt_nxt   = '0;
        state_nxt = SPAWN_CHK;
      end

      SPAWN_CHK: begin
        if (collide_here) begin
          over_nxt  = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = OVER;
        end else begin
          valid_nxt = 1'b1;
          state_nxt = FALL;
        end
      end

      FALL: begin
        // Saturating count keeps a deferred gravity step pending.
        if (frame_tick && (grav_cnt < threshold)) cnt_nxt = grav_cnt + CW'(1);
        if (key_armed && key_edge) armed_nxt = 1'b0;

        if (key_armed && key_hard) begin
          state_nxt = HARD;
        end else if (key_armed && key_hold && !hold_used) begin
          hold_nxt  = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = SPAWN_WAIT;
        end else if (key_armed && key_left && !collide_left) begin
          x_nxt = piece_x - 4'd1;
        end else if (key_armed && key_right && !collide_right) begin
          x_nxt = piece_x + 4'd1;
        end else if (grav_pending && !collide_down) begin
          y_nxt   = piece_y + 5'd1;
          cnt_nxt = '0;
        end else if (grav_pending) begin
          state_nxt = LOCK;
        end
      end

      HARD: begin
        if (!collide_down) y_nxt = piece_y + 5'd1;
        else               state_nxt = LOCK;
      end

      LOCK: begin
        touchdown = 1'b1;
        valid_nxt = 1'b0;
        hold_nxt  = 1'b0;
        state_nxt = SPAWN_WAIT;
      end

      OVER: state_nxt = OVER;

      default: state_nxt = SPAWN_WAIT;
    endcase
  end

endmodule
